// File: rtl/adc_fsync_rx_mc_pkg.sv
// Shared types and helpers for the multi-channel fsync-master ADC receiver.
// Covers FSM states, sync depth, FIFO entry packing and sign extension.
package adc_rx_pkg;

  typedef enum logic [1:0] {IDLE, RECV, PUSH} state_t;

  localparam int SYNC_DEPTH     = 2;
  localparam int ENTRY_DATA_LSB = 0;
  localparam int SEXT_MAX_W     = 64;

  // Widen a data_w-bit two's-complement sample to out_w bits. Bits above out_w are zero.
  function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] sample,
                                                 input int data_w, input int out_w);
    logic [SEXT_MAX_W-1:0] r;
    logic                  sign;
    r    = '0;
    sign = 1'b0;
    for (int i = 0; i < SEXT_MAX_W; i++) begin
      if (i == data_w - 1) sign = sample[i];
    end
    for (int i = 0; i < SEXT_MAX_W; i++) begin
      if (i < out_w) r[i] = (i < data_w) ? sample[i] : sign;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_fsync_rx_mc_if.sv
// Valid/ready sample stream carrying a sign-extended word and its channel tag.
interface adc_fsync_rx_mc_if #(
  parameter int OUT_W  = 32,
  parameter int CHAN_W = 2
);
  logic              valid;
  logic              ready;
  logic [OUT_W-1:0]  data;
  logic [CHAN_W-1:0] chan;

  modport master (output valid, data, chan, input ready);
  modport slave  (input valid, data, chan, output ready);
endinterface

// File: rtl/adc_fsync_rx_mc_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
// Read data is forced to zero while empty so the stream idles at a known value.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = count[AW];
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; pointers alone define valid contents.
  always_ff @(posedge aclk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/adc_fsync_rx_mc.sv
// Multi-channel receiver for fsync-master delta-sigma ADCs: synchronise, deserialise,
// then write whole frames as channel-tagged words into a FWFT FIFO.
module adc_fsync_rx_mc
  import adc_rx_pkg::*;
#(
  parameter int CH         = 4,
  parameter int DATA_W     = 24,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        en,
  input  logic                        clear_stat,
  input  logic                        sck,
  input  logic                        fsync,
  input  logic [CH-1:0]               dout,
  adc_fsync_rx_mc_if.master           m,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]            frame_cnt,
  output logic [CNT_W-1:0]            drop_cnt,
  output logic [CNT_W-1:0]            err_cnt,
  output logic                        overflow
);

  localparam int CHAN_W         = (CH > 1) ? $clog2(CH) : 1;
  localparam int BCW            = $clog2(DATA_W);
  localparam int FCW            = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_CHAN_LSB = ENTRY_DATA_LSB + OUT_W;
  localparam int ENTRY_W        = OUT_W + CHAN_W;

  localparam logic [BCW-1:0]    LAST_BIT  = BCW'(DATA_W - 1);
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CH - 1);
  localparam logic [FCW-1:0]    MAX_FILL  = FCW'(FIFO_DEPTH - CH);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [SYNC_DEPTH:0]             sck_sync;
  logic [SYNC_DEPTH:0]             fsync_sync;
  logic [SYNC_DEPTH-1:0][CH-1:0]   dout_sync;
  logic                            sck_rise;
  logic                            fsync_rise;
  logic [CH-1:0]                   dout_s2;

  state_t                          state_q, state_d;
  logic [BCW-1:0]                  bitcnt_q, bitcnt_d;
  logic [CHAN_W-1:0]               push_idx_q, push_idx_d;
  // Shift registers double as the frame holding registers once the last bit lands.
  logic [CH-1:0][DATA_W-1:0]       sr_q, sr_d;

  logic                            push;
  logic                            inc_frame, inc_drop, inc_err;
  logic                            space_ok;
  logic [SEXT_MAX_W-1:0]           sext_word;
  logic [ENTRY_W-1:0]              fifo_wdata;
  logic [ENTRY_W-1:0]              fifo_rdata;
  logic                            fifo_full, fifo_empty;

  always_ff @(posedge aclk) begin
    if (areset) begin
      sck_sync   <= '0;
      fsync_sync <= '0;
      dout_sync  <= '0;
    end else begin
      sck_sync   <= {sck_sync[SYNC_DEPTH-1:0], sck};
      fsync_sync <= {fsync_sync[SYNC_DEPTH-1:0], fsync};
      dout_sync  <= {dout_sync[SYNC_DEPTH-2:0], dout};
    end
  end

  assign sck_rise   = sck_sync[SYNC_DEPTH-1] & ~sck_sync[SYNC_DEPTH];
  assign fsync_rise = fsync_sync[SYNC_DEPTH-1] & ~fsync_sync[SYNC_DEPTH];
  assign dout_s2    = dout_sync[SYNC_DEPTH-1];
  assign space_ok   = (fifo_count <= MAX_FILL);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    push_idx_d = push_idx_q;
    sr_d       = sr_q;
    push       = 1'b0;
    inc_frame  = 1'b0;
    inc_drop   = 1'b0;
    inc_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && fsync_rise) begin
          state_d  = RECV;
          bitcnt_d = '0;
          sr_d     = '0;
        end
      end
      RECV: begin
        if (!en) begin
          state_d = IDLE;
        end else if (fsync_rise) begin
          inc_err  = 1'b1;
          bitcnt_d = '0;
          sr_d     = '0;
        end else if (sck_rise) begin
          for (int c = 0; c < CH; c++) sr_d[c] = {sr_q[c][DATA_W-2:0], dout_s2[c]};
          if (bitcnt_q == LAST_BIT) begin
            if (space_ok) begin
              state_d    = PUSH;
              push_idx_d = '0;
            end else begin
              inc_drop = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      PUSH: begin
        push = 1'b1;
        if (fsync_rise) inc_err = 1'b1;
        if (push_idx_q == LAST_CHAN) begin
          inc_frame = 1'b1;
          state_d   = IDLE;
        end else begin
          push_idx_d = push_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      push_idx_q <= '0;
      sr_q       <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      push_idx_q <= push_idx_d;
      sr_q       <= sr_d;
    end
  end

  always_comb begin
    sext_word  = sext(SEXT_MAX_W'(sr_q[push_idx_q]), DATA_W, OUT_W);
    fifo_wdata = '0;
    fifo_wdata[ENTRY_DATA_LSB +: OUT_W]  = sext_word[OUT_W-1:0];
    fifo_wdata[ENTRY_CHAN_LSB +: CHAN_W] = push_idx_q;
  end

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (push && !fifo_full),
    .wdata  (fifo_wdata),
    .pop    (m.valid && m.ready),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign m.valid = !fifo_empty;
  assign m.data  = fifo_rdata[ENTRY_DATA_LSB +: OUT_W];
  assign m.chan  = fifo_rdata[ENTRY_CHAN_LSB +: CHAN_W];

  // Clear has priority over any coincident increment.
  always_ff @(posedge aclk) begin
    if (areset || clear_stat) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
      err_cnt   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (inc_frame && frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + 1'b1;
      if (inc_drop  && drop_cnt  != CNT_MAX) drop_cnt  <= drop_cnt + 1'b1;
      if (inc_err   && err_cnt   != CNT_MAX) err_cnt   <= err_cnt + 1'b1;
      if (inc_drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_fsync_rx_mc.sv
// Directed bench for adc_fsync_rx_mc: serial frames in, scoreboarded stream out.
module tb_adc_fsync_rx_mc;

  localparam int CH         = 4;
  localparam int DATA_W     = 24;
  localparam int OUT_W      = 32;
  localparam int FIFO_DEPTH = 64;
  localparam int CNT_W      = 16;
  localparam int CHAN_W     = 2;
  localparam int HALF       = 4;

  typedef logic [CHAN_W+OUT_W-1:0]   word_t;
  typedef logic [CH-1:0][DATA_W-1:0] frame_t;

  logic                  aclk = 1'b0;
  logic                  areset;
  logic                  en;
  logic                  clear_stat;
  logic                  sck;
  logic                  fsync;
  logic [CH-1:0]         dout;
  logic [6:0]            fifo_count;
  logic [CNT_W-1:0]      frame_cnt, drop_cnt, err_cnt;
  logic                  overflow;

  int    checks = 0;
  int    errors = 0;
  int    words_seen = 0;
  word_t exp_q[$];

  adc_fsync_rx_mc_if #(.OUT_W(OUT_W), .CHAN_W(CHAN_W)) m_if ();

  adc_fsync_rx_mc #(
    .CH(CH), .DATA_W(DATA_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .en         (en),
    .clear_stat (clear_stat),
    .sck        (sck),
    .fsync      (fsync),
    .dout       (dout),
    .m          (m_if),
    .fifo_count (fifo_count),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .err_cnt    (err_cnt),
    .overflow   (overflow)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Words are popped at the next posedge whenever valid & ready hold at the negedge.
  always @(negedge aclk) begin
    word_t got;
    if (!areset && m_if.valid && m_if.ready) begin
      got = {m_if.chan, m_if.data};
      words_seen++;
      if (exp_q.size() == 0) check("unexpected_word", 64'(got), 64'hDEAD_0000_0000_0000);
      else check("stream_word", 64'(got), 64'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic fsync_pulse();
    fsync = 1'b1;
    tick(HALF);
    fsync = 1'b0;
    tick(HALF);
  endtask

  task automatic send_bits(input frame_t f, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CH; c++) dout[c] = f[c][DATA_W-1-b];
      sck = 1'b0;
      tick(HALF);
      sck = 1'b1;
      tick(HALF);
    end
    sck = 1'b0;
    tick(2 * HALF);
  endtask

  // Drives the final bit and leaves sck high right after a posedge.
  task automatic last_bit_rise(input frame_t f);
    for (int c = 0; c < CH; c++) dout[c] = f[c][0];
    sck = 1'b0;
    tick(HALF);
    sck = 1'b1;
  endtask

  task automatic expect_frame(input frame_t f);
    for (int c = 0; c < CH; c++)
      exp_q.push_back({CHAN_W'(c), {(OUT_W-DATA_W){f[c][DATA_W-1]}}, f[c]});
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int c = 0; c < CH; c++) f[c] = DATA_W'($urandom);
    return f;
  endfunction

  task automatic full_frame(input frame_t f, input bit accept);
    fsync_pulse();
    if (accept) expect_frame(f);
    send_bits(f, DATA_W);
  endtask

  task automatic drain(input string tag, input int max_cycles);
    m_if.ready = 1'b1;
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick(1);
    tick(2);
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clear_counters();
    clear_stat = 1'b1;
    tick(1);
    clear_stat = 1'b0;
    tick(1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    int     ws;

    areset = 1'b1; en = 1'b0; clear_stat = 1'b0;
    sck = 1'b0; fsync = 1'b0; dout = '0; m_if.ready = 1'b0;
    tick(3);
    check("rst_valid", 64'(m_if.valid), 64'd0);
    check("rst_data", 64'(m_if.data), 64'd0);
    check("rst_chan", 64'(m_if.chan), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    areset = 1'b0; en = 1'b1; m_if.ready = 1'b1;
    tick(4);

    // Sign-extension boundary values plus first-word latency.
    f[0] = 24'h7FFFFF; f[1] = 24'h800000; f[2] = 24'h000001; f[3] = 24'hFFFFFF;
    fsync_pulse();
    expect_frame(f);
    send_bits(f, DATA_W - 1);
    last_bit_rise(f);
    tick(3);
    check("latency_early", 64'(m_if.valid), 64'd0);
    tick(1);
    check("latency_valid", 64'(m_if.valid), 64'd1);
    check("latency_chan", 64'(m_if.chan), 64'd0);
    check("latency_data", 64'(m_if.data), 64'h007FFFFF);
    tick(HALF);
    sck = 1'b0;
    tick(2 * HALF);
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Fill with 16 frames, drop the 17th, then drain 64 words.
    m_if.ready = 1'b0;
    tick(1);
    for (int k = 0; k < 16; k++) full_frame(rand_frame(), 1'b1);
    full_frame(rand_frame(), 1'b0);
    check("ovf_fifo_count", 64'(fifo_count), 64'd64);
    check("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_frame_cnt", 64'(frame_cnt), 64'd17);
    ws = words_seen;
    drain("ovf_drain", 200);
    check("ovf_drained_words", 64'(words_seen - ws), 64'd64);

    clear_counters();
    check("clr_frame_cnt", 64'(frame_cnt), 64'd0);
    check("clr_drop_cnt", 64'(drop_cnt), 64'd0);
    check("clr_overflow", 64'(overflow), 64'd0);

    // Truncated frame followed by a complete one.
    fsync_pulse();
    send_bits(rand_frame(), 10);
    full_frame(rand_frame(), 1'b1);
    tick(4);
    check("err_err_cnt", 64'(err_cnt), 64'd1);
    check("err_frame_cnt", 64'(frame_cnt), 64'd1);
    drain("err_drain", 50);

    // Enable dropped mid-frame: no output, no counter change.
    clear_counters();
    fsync_pulse();
    send_bits(rand_frame(), 12);
    en = 1'b0;
    tick(8);
    en = 1'b1;
    tick(8);
    check("en_valid", 64'(m_if.valid), 64'd0);
    check("en_fifo_count", 64'(fifo_count), 64'd0);
    check("en_counters", 64'({frame_cnt, drop_cnt, err_cnt}), 64'd0);
    full_frame(rand_frame(), 1'b1);
    drain("en_drain", 50);
    check("en_frame_cnt", 64'(frame_cnt), 64'd1);

    // Reset asserted after two PUSH writes.
    m_if.ready = 1'b0;
    f = rand_frame();
    fsync_pulse();
    send_bits(f, DATA_W - 1);
    last_bit_rise(f);
    tick(5);
    check("rstp_partial_count", 64'(fifo_count), 64'd2);
    areset = 1'b1;
    sck = 1'b0;
    tick(1);
    check("rstp_valid", 64'(m_if.valid), 64'd0);
    check("rstp_fifo_count", 64'(fifo_count), 64'd0);
    areset = 1'b0;
    tick(4);
    m_if.ready = 1'b1;
    full_frame(rand_frame(), 1'b1);
    drain("rstp_drain", 50);
    check("rstp_frame_cnt", 64'(frame_cnt), 64'd1);

    // clear_stat coincident with a drop: clear wins.
    m_if.ready = 1'b0;
    tick(1);
    for (int k = 0; k < 16; k++) full_frame(rand_frame(), 1'b1);
    check("cd_frame_cnt_pre", 64'(frame_cnt), 64'd17);
    f = rand_frame();
    fsync_pulse();
    send_bits(f, DATA_W - 1);
    last_bit_rise(f);
    tick(2);
    clear_stat = 1'b1;
    tick(1);
    clear_stat = 1'b0;
    check("cd_drop_cnt", 64'(drop_cnt), 64'd0);
    check("cd_overflow", 64'(overflow), 64'd0);
    check("cd_frame_cnt", 64'(frame_cnt), 64'd0);
    tick(2);
    check("cd_drop_cnt_hold", 64'(drop_cnt), 64'd0);
    check("cd_overflow_hold", 64'(overflow), 64'd0);
    check("cd_fifo_count", 64'(fifo_count), 64'd64);
    sck = 1'b0;
    tick(HALF);
    drain("cd_drain", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_fsync_rx_mc.md
Name: adc_fsync_rx_mc

Overview:
Parametrised multi-channel receiver for frame-sync-master delta-sigma ADCs (ADS127L01 class) operating in master-fsync mode. It captures CH parallel dout lines on the ADC's sck/fsync and sign-extends each DATA_W-bit sample to OUT_W bits. Samples are buffered in a FIFO as channel-tagged words and presented on a valid/ready stream to the AXI-Lite data register bank in the LPDAQ subsystem. Compared with the single-channel 24-bit receiver it adds:
- a configurable channel count and widths;
- whole-frame overflow dropping;
- frame-error detection;
- saturating statistics counters.

Parameters:
- CH, 4, number of parallel dout lines (1..16).
- DATA_W, 24, bits per sample, MSB first.
- OUT_W, 32, output word width; must be ≥ DATA_W.
- FIFO_DEPTH, 64, FIFO entries; power of two, ≥ CH.
- CNT_W, 16, width of the statistics counters.

Ports:
- aclk, in, 1, system clock (100 MHz).
- areset, in, 1, synchronous active-high reset.
- en, in, 1, capture enable.
- clear_stat, in, 1, single-cycle pulse; clears the counters and the sticky flag.
- sck, in, 1, ADC serial clock, asynchronous.
- fsync, in, 1, ADC frame sync, asynchronous.
- dout, in, CH, ADC data lines, asynchronous.
- m_valid, out, 1, stream word valid.
- m_ready, in, 1, stream consumer ready.
- m_data, out, OUT_W, sign-extended sample.
- m_chan, out, max(1,$clog2(CH)), channel index of m_data.
- fifo_count, out, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
- frame_cnt, out, CNT_W, frames accepted into the FIFO.
- drop_cnt, out, CNT_W, frames dropped for lack of space.
- err_cnt, out, CNT_W, truncated or unexpected frames.
- overflow, out, 1, sticky flag; set on any drop.

Behaviour:
- Reset (areset=1 at a clock edge):
  - FSM enters IDLE; FIFO is emptied.
  - m_valid=0, m_data=0, m_chan=0, fifo_count=0.
  - All counters are 0; overflow=0; synchroniser flops are 0.
  - Reset mid-frame or mid-push discards all partial data.
- Input synchronisation:
  - sck, fsync and dout each pass through 2 flops, then a 3rd flop for edge detection.
  - sck_rise = s2 & ~s3; fsync_rise is formed the same way.
  - dout is sampled from its s2 stage on the sck_rise cycle.
- FSM states: IDLE, RECV, PUSH.
- IDLE:
  - en=1 and fsync_rise → RECV, with bitcnt=0 and all shift registers cleared.
- RECV:
  - On each sck_rise: each channel shift reg ← {sr[DATA_W-2:0], dout[c]}; bitcnt++.
  - An sck_rise in the same cycle as fsync_rise is ignored.
  - When the DATA_W-th bit shifts in:
    - if free space (FIFO_DEPTH − fifo_count) ≥ CH → latch all CH samples into the holding regs, go to PUSH;
    - otherwise drop_cnt++, overflow=1, go to IDLE (whole frame dropped, never a partial frame).
  - fsync_rise before DATA_W bits → err_cnt++, restart RECV with bitcnt=0.
  - en=0 → IDLE; the partial frame is discarded and no counter changes.
- PUSH:
  - Writes one FIFO entry per cycle for ch 0..CH-1 (exactly CH cycles), then frame_cnt++ and go to IDLE.
  - Entry = {chan, sign-extended sample}, where sign-extended sample = {{(OUT_W-DATA_W){s[DATA_W-1]}}, s}.
  - fsync_rise during PUSH → err_cnt++; the edge is ignored, so the next frame is missed.
  - en=0 during PUSH does not abort the push.
- FIFO:
  - First-word-fall-through; m_valid = !empty; pop on m_valid & m_ready.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - The FIFO never overflows, because space for the whole frame is checked before PUSH.
  - m_data and m_chan stay stable while m_valid & !m_ready.
- Latency: last-bit sck rising edge at the pin → first word m_valid = 4 aclk edges (2 sync + 1 edge detect + 1 PUSH write), FIFO initially empty.
- Counters:
  - Saturate at 2^CNT_W − 1.
  - clear_stat zeroes all counters and overflow in the next cycle.
  - If an increment coincides with clear_stat, clear wins.
- Timing: sck high and low periods must each be ≥ 3 aclk periods; faster sck is outside the operating range.

Decomposition:
- Package adc_rx_pkg:
  - typedef state_t {IDLE, RECV, PUSH};
  - function sext(sample, DATA_W, OUT_W);
  - localparams for the sync depth (2) and FIFO-entry packing offsets.
- Sub-module sync_fifo_fwft:
  - parameters WIDTH, DEPTH;
  - ports push/pop/full/empty/count;
  - circular pointers with an extra wrap bit.
- Everything else lives in the top level: synchroniser, edge detect, shifters, FSM, counters.

Test Plan:
- CH=4, DATA_W=24 model frame with ch0..3 = 0x7FFFFF, 0x800000, 0x000001, 0xFFFFFF, m_ready=1 → words in order:
  - chan 0 = 0x007FFFFF;
  - chan 1 = 0xFF800000;
  - chan 2 = 0x00000001;
  - chan 3 = 0xFFFFFFFF;
  - frame_cnt=1.
- Latency: check that the first m_valid arrives 4 aclk after the last sck pin rise, with m_chan=0.
- m_ready=0, FIFO_DEPTH=64, CH=4, 17 frames →
  - 16 frames accepted, fifo_count=64;
  - 17th dropped: drop_cnt=1, overflow=1;
  - after draining, the stream contains exactly 64 words, channels cycling 0..3.
- fsync pulse after 10 bits, then a full frame → err_cnt=1, frame_cnt=1, only the full frame's CH words are output.
- en deasserted after 12 bits, then reasserted before the next fsync → no output, all counters 0; the next full frame is received normally.
- areset asserted during PUSH after 2 words written → m_valid=0 and fifo_count=0 next cycle; the following frame is received intact.
- Coincident clear_stat and a drop event → drop_cnt=0 and overflow=0 after the cycle.
